// File: rtl/fx_pkg.sv
// Shared definitions for the fx_mac datapath family: default widths, the
// sequencer state encoding and small elaboration helpers.
package fx_pkg;

  localparam int WIDTH_DEF    = 8;
  localparam int FRACTION_DEF = 4;
  localparam int GAP_MIN      = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_WAIT   = 3'd2,
    S_HOLD   = 3'd3,
    S_GAP    = 3'd4
  } seq_state_e;

  // Index/counter width for n distinct values, never narrower than one bit.
  function automatic int aw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fx_vec_buf.sv
// K x WIDTH register file: one synchronous write port, one combinational
// read port, cleared by reset.
module fx_vec_buf #(
  parameter int WIDTH = 8,
  parameter int K     = 4,
  parameter int AW    = 2
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [K];

  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      for (int i = 0; i < K; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fx_mac_seq.sv
// Burst sequencer in front of one fx_mac: buffers a weight and a data vector,
// streams them as one K-cycle burst, captures the MAC result and hands it off.
module fx_mac_seq
  import fx_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int K        = 4,
  parameter int FRACTION = FRACTION_DEF,
  parameter int GAP      = GAP_MIN,
  parameter int TIMEOUT  = 64,
  localparam int AW      = aw_f(K)
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic             wr_en_i,
  input  logic             wr_sel_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             mac_vld_o,
  output logic [WIDTH-1:0] mac_win_o,
  output logic [WIDTH-1:0] mac_din_o,
  input  logic [WIDTH-1:0] mac_acc_i,
  input  logic             mac_vld_i,
  output logic [WIDTH-1:0] res_o,
  output logic             res_vld_o,
  input  logic             res_rdy_i,
  output logic             err_o
);

  localparam int IW = aw_f(K + 1);
  localparam int TW = aw_f(TIMEOUT);
  localparam int GW = aw_f(GAP);

  if (GAP < GAP_MIN || FRACTION >= WIDTH) begin : g_cfg_bad
    $error("fx_mac_seq: GAP below minimum or FRACTION not below WIDTH");
  end

  seq_state_e       state_q;
  logic [IW-1:0]    idx_q;
  logic [TW-1:0]    timer_q;
  logic [GW-1:0]    gap_q;
  logic             mac_vld_q;
  logic [WIDTH-1:0] mac_win_q;
  logic [WIDTH-1:0] mac_din_q;
  logic [WIDTH-1:0] res_q;
  logic             res_vld_q;
  logic             err_q;

  logic             wr_ok;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] wbuf_rd;
  logic [WIDTH-1:0] dbuf_rd;
  logic             byp0;
  logic [WIDTH-1:0] win0;
  logic [WIDTH-1:0] din0;

  assign wr_ok   = (state_q == S_IDLE) && wr_en_i &&
                   ({1'b0, wr_addr_i} < (AW + 1)'(K));
  assign rd_addr = (state_q == S_IDLE) ? '0 : AW'(idx_q);

  fx_vec_buf #(.WIDTH(WIDTH), .K(K), .AW(AW)) u_wbuf (
    .clk_i   (clk_i),
    .rstn    (rstn),
    .we_i    (wr_ok && !wr_sel_i),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .raddr_i (rd_addr),
    .rdata_o (wbuf_rd)
  );

  fx_vec_buf #(.WIDTH(WIDTH), .K(K), .AW(AW)) u_dbuf (
    .clk_i   (clk_i),
    .rstn    (rstn),
    .we_i    (wr_ok && wr_sel_i),
    .waddr_i (wr_addr_i),
    .wdata_i (wr_data_i),
    .raddr_i (rd_addr),
    .rdata_o (dbuf_rd)
  );

  // A write to element 0 in the start cycle must reach the first operand.
  assign byp0 = wr_ok && (wr_addr_i == '0);
  assign win0 = (byp0 && !wr_sel_i) ? wr_data_i : wbuf_rd;
  assign din0 = (byp0 && wr_sel_i)  ? wr_data_i : dbuf_rd;

  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      timer_q   <= '0;
      gap_q     <= '0;
      mac_vld_q <= 1'b0;
      mac_win_q <= '0;
      mac_din_q <= '0;
      res_q     <= '0;
      res_vld_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q   <= S_STREAM;
            err_q     <= 1'b0;
            idx_q     <= IW'(1);
            mac_vld_q <= 1'b1;
            mac_win_q <= win0;
            mac_din_q <= din0;
          end
        end
        S_STREAM: begin
          if (idx_q == IW'(K)) begin
            state_q   <= S_WAIT;
            timer_q   <= '0;
            mac_vld_q <= 1'b0;
            mac_win_q <= '0;
            mac_din_q <= '0;
          end else begin
            idx_q     <= idx_q + IW'(1);
            mac_win_q <= wbuf_rd;
            mac_din_q <= dbuf_rd;
          end
        end
        S_WAIT: begin
          if (mac_vld_i) begin
            state_q   <= S_HOLD;
            res_q     <= mac_acc_i;
            res_vld_q <= 1'b1;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_q <= S_GAP;
            gap_q   <= '0;
            err_q   <= 1'b1;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_HOLD: begin
          if (res_rdy_i) begin
            state_q   <= S_GAP;
            gap_q     <= '0;
            res_vld_q <= 1'b0;
          end
        end
        S_GAP: begin
          if (gap_q == GW'(GAP - 1)) begin
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign mac_vld_o = mac_vld_q;
  assign mac_win_o = mac_win_q;
  assign mac_din_o = mac_din_q;
  assign res_o     = res_q;
  assign res_vld_o = res_vld_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_fx_mac_seq.sv
// Directed bench for fx_mac_seq with a small behavioural Q4.4 MAC on the
// downstream side (latency 2 after the last element, saturating).
module tb_fx_mac_seq;

  logic       clk_i = 1'b0;
  logic       rstn;
  logic       wr_en_i, wr_sel_i;
  logic [1:0] wr_addr_i;
  logic [7:0] wr_data_i;
  logic       start_i;
  logic       busy_o, mac_vld_o;
  logic [7:0] mac_win_o, mac_din_o;
  logic [7:0] mac_acc_i;
  logic       mac_vld_i;
  logic [7:0] res_o;
  logic       res_vld_o, res_rdy_i, err_o;

  int nvec = 0;
  int nfail = 0;

  always #5 clk_i = ~clk_i;

  fx_mac_seq #(.WIDTH(8), .K(4), .FRACTION(4), .GAP(6), .TIMEOUT(64)) dut (
    .clk_i     (clk_i),
    .rstn      (rstn),
    .wr_en_i   (wr_en_i),
    .wr_sel_i  (wr_sel_i),
    .wr_addr_i (wr_addr_i),
    .wr_data_i (wr_data_i),
    .start_i   (start_i),
    .busy_o    (busy_o),
    .mac_vld_o (mac_vld_o),
    .mac_win_o (mac_win_o),
    .mac_din_o (mac_din_o),
    .mac_acc_i (mac_acc_i),
    .mac_vld_i (mac_vld_i),
    .res_o     (res_o),
    .res_vld_o (res_vld_o),
    .res_rdy_i (res_rdy_i),
    .err_o     (err_o)
  );

  // Downstream MAC model
  logic              mac_en, man_vld, model_vld;
  logic [7:0]        man_acc, model_acc;
  logic signed [31:0] acc_m;
  int                cnt_m, lat_m;

  function automatic logic [7:0] sat_q44(input logic signed [31:0] a);
    logic signed [31:0] s;
    s = a >>> 4;
    if (s > 127) return 8'h7F;
    if (s < -128) return 8'h80;
    return s[7:0];
  endfunction

  always @(posedge clk_i) begin
    model_vld <= 1'b0;
    if (!rstn) begin
      acc_m <= 0; cnt_m <= 0; lat_m <= 0;
    end else begin
      if (mac_vld_o) begin
        acc_m <= acc_m + $signed(mac_win_o) * $signed(mac_din_o);
        cnt_m <= cnt_m + 1;
        if (cnt_m == 3) lat_m <= 2;
      end
      if (lat_m > 0) begin
        lat_m <= lat_m - 1;
        if (lat_m == 1) begin
          model_vld <= mac_en;
          model_acc <= sat_q44(acc_m);
          acc_m <= 0;
          cnt_m <= 0;
        end
      end
    end
  end

  assign mac_vld_i = model_vld | man_vld;
  assign mac_acc_i = man_vld ? man_acc : model_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [1:0] addr, input logic [7:0] data);
    wr_en_i = 1'b1; wr_sel_i = sel; wr_addr_i = addr; wr_data_i = data;
    @(negedge clk_i);
    wr_en_i = 1'b0;
  endtask

  task automatic load(input logic [7:0] w0, w1, w2, w3, d0, d1, d2, d3);
    wr(0, 0, w0); wr(0, 1, w1); wr(0, 2, w2); wr(0, 3, w3);
    wr(1, 0, d0); wr(1, 1, d1); wr(1, 2, d2); wr(1, 3, d3);
  endtask

  // Launch a burst, check first operands, vld shape, then the captured result.
  task automatic burst(input string tag, input logic [7:0] w0, d0, exp_res);
    int n, vcnt, runs;
    logic prev;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; wr_en_i = 1'b0;
    chk({tag, "_vld0"}, mac_vld_o, 1);
    chk({tag, "_win0"}, mac_win_o, w0);
    chk({tag, "_din0"}, mac_din_o, d0);
    chk({tag, "_err0"}, err_o, 0);
    n = 0; vcnt = 0; runs = 0; prev = 1'b0;
    while (!res_vld_o && n < 100) begin
      if (mac_vld_o) vcnt++;
      if (mac_vld_o && !prev) runs++;
      prev = mac_vld_o;
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_res_seen"}, res_vld_o, 1);
    chk({tag, "_vld_cycles"}, vcnt, 4);
    chk({tag, "_vld_runs"}, runs, 1);
    chk({tag, "_res"}, res_o, exp_res);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_idle"}, busy_o, 0);
  endtask

  task automatic accept(input string tag);
    res_rdy_i = 1'b1;
    @(negedge clk_i);
    res_rdy_i = 1'b0;
    chk({tag, "_vld_drop"}, res_vld_o, 0);
    wait_idle(tag);
  endtask

  initial begin
    int k, lowrun, minlow, bursts;
    logic prev, rv_seen, stable;
    rstn = 1'b0; wr_en_i = 0; wr_sel_i = 0; wr_addr_i = 0; wr_data_i = 0;
    start_i = 0; res_rdy_i = 0; mac_en = 1; man_vld = 0; man_acc = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_mac_vld", mac_vld_o, 0);
    chk("rst_res_vld", res_vld_o, 0);
    chk("rst_res", res_o, 0);
    chk("rst_err", err_o, 0);
    rstn = 1'b1;
    @(negedge clk_i);

    // Basic loop: 1.0 * (1.0 + 2.0 + 0.5 + 1.5) = 5.0
    load(8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h20, 8'h08, 8'h18);
    burst("basic", 8'h10, 8'h10, 8'h50);
    repeat (3) @(negedge clk_i);
    chk("basic_hold_vld", res_vld_o, 1);
    chk("basic_hold_res", res_o, 8'h50);
    accept("basic");

    // Saturation; w0 written in the start cycle must be used
    load(8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
    wr_en_i = 1; wr_sel_i = 0; wr_addr_i = 0; wr_data_i = 8'h7F;
    burst("sat", 8'h7F, 8'h7F, 8'h7F);
    accept("sat");

    // Timeout: MAC never answers
    mac_en = 0;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    k = 0;
    while (mac_vld_o && k < 20) begin
      @(negedge clk_i);
      k++;
    end
    rv_seen = 1'b0;
    for (int j = 0; j <= 70; j++) begin
      if (res_vld_o) rv_seen = 1'b1;
      if (j == 63) chk("tmo_err_early", err_o, 0);
      if (j == 64) chk("tmo_err_set", err_o, 1);
      if (j == 69) chk("tmo_gap_busy", busy_o, 1);
      if (j == 70) chk("tmo_idle", busy_o, 0);
      if (j < 70) @(negedge clk_i);
    end
    chk("tmo_no_res", rv_seen, 0);
    chk("tmo_err_sticky", err_o, 1);
    mac_en = 1;
    burst("tmo_next", 8'h7F, 8'h7F, 8'h7F);
    accept("tmo_next");

    // Backpressure with start/write attempts during HOLD
    load(8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h20, 8'h08, 8'h18);
    burst("bp", 8'h10, 8'h10, 8'h50);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start_i = (i == 3); wr_en_i = (i == 3);
      wr_sel_i = 0; wr_addr_i = 0; wr_data_i = 8'h55;
      @(negedge clk_i);
      if (res_o !== 8'h50 || res_vld_o !== 1'b1 || mac_vld_o !== 1'b0) stable = 1'b0;
    end
    start_i = 0; wr_en_i = 0;
    chk("bp_stable", stable, 1);
    accept("bp");
    burst("bp_next", 8'h10, 8'h10, 8'h50);
    accept("bp_next");

    // Back-to-back starts with a ready consumer
    res_rdy_i = 1'b1; start_i = 1'b1;
    prev = 1'b0; lowrun = 0; minlow = 1000; bursts = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_i);
      if (mac_vld_o) begin
        if (!prev) begin
          if (bursts > 0 && lowrun < minlow) minlow = lowrun;
          bursts++;
        end
        lowrun = 0;
      end else begin
        lowrun++;
      end
      if (res_vld_o) chk("b2b_res", res_o, 8'h50);
      prev = mac_vld_o;
    end
    start_i = 1'b0;
    wait_idle("b2b");
    res_rdy_i = 1'b0;
    chk("b2b_bursts", (bursts >= 3), 1);
    chk("b2b_gap", (minlow >= 6), 1);

    // Reset while streaming element 2
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk("rmid_streaming", mac_vld_o, 1);
    rstn = 1'b0;
    @(negedge clk_i);
    chk("rmid_vld", mac_vld_o, 0);
    chk("rmid_busy", busy_o, 0);
    rstn = 1'b1;
    man_acc = 8'h33; man_vld = 1'b1;
    @(negedge clk_i);
    man_vld = 1'b0;
    @(negedge clk_i);
    chk("rmid_late_vld", res_vld_o, 0);
    chk("rmid_late_res", res_o, 0);
    chk("rmid_late_busy", busy_o, 0);
    burst("rmid_clear", 8'h00, 8'h00, 8'h00);
    accept("rmid_clear");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/fx_mac_seq.md
Name: fx_mac_seq

Overview:
- Sequencer and transmitter that feeds the fx_mac accumulator.
- Holds one K-element weight vector and one K-element data vector in local registers, loaded over a simple write port.
- On start, streams the K (weight, data) pairs to the MAC as one burst, enforces the inter-vector idle gap, then captures the MAC result.
- Presents the result on a valid/ready output; sits between the layer controller and one fx_mac instance.

Parameters:
- WIDTH, 8: bitwidth of weights, data and result (signed, fixed point).
- K, 4: pairs per burst; must match the downstream fx_mac K.
- FRACTION, 4: fractional bits; passed through for the shared package, no arithmetic use here.
- GAP, 6: minimum idle cycles with mac_vld_o low after a burst before the next one (must be >= 6).
- TIMEOUT, 64: maximum cycles to wait for mac_vld_i after a burst ends.

Ports:
- clk_i  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- wr_en_i  in  1  write strobe for the vector buffers
- wr_sel_i  in  1  0 = weight buffer, 1 = data buffer
- wr_addr_i  in  AW  element index, AW = max(1, $clog2(K))
- wr_data_i  in  WIDTH  element value
- start_i  in  1  launch one burst (pulse)
- busy_o  out  1  high in every state except IDLE
- mac_vld_o  out  1  MAC input valid
- mac_win_o  out  WIDTH  MAC weight operand
- mac_din_o  out  WIDTH  MAC data operand
- mac_acc_i  in  WIDTH  MAC result
- mac_vld_i  in  1  MAC result valid (1-cycle pulse)
- res_o  out  WIDTH  captured result
- res_vld_o  out  1  result valid
- res_rdy_i  in  1  result consumer ready
- err_o  out  1  sticky timeout flag; cleared by the next accepted start_i

Behaviour:
- Reset (rstn = 0 at a clock edge):
  - All outputs go to 0; FSM goes to IDLE; counters and both buffers clear to 0.
  - Reset mid-operation aborts the operation immediately; no result is produced.
- Writes:
  - Accepted only in IDLE with wr_en_i = 1 and wr_addr_i < K.
  - Otherwise the write is silently dropped.
  - Buffer contents persist across bursts.
- FSM states: IDLE, STREAM, WAIT, HOLD, GAP.
- IDLE:
  - start_i = 1 moves to STREAM, clears err_o and idx.
  - start_i outside IDLE is ignored.
  - start_i and wr_en_i in the same IDLE cycle: the write takes effect and the burst uses the new value.
- STREAM:
  - Outputs are registered: mac_vld_o = 1, mac_win_o = wbuf[idx], mac_din_o = dbuf[idx].
  - Start accepted at edge t gives mac_vld_o high exactly on cycles t+1 .. t+K, contiguous.
  - After the K-th element, move to WAIT; mac_vld_o = 0 and the operands return to 0.
- WAIT:
  - Timer counts from 0.
  - mac_vld_i = 1: res_o <= mac_acc_i, res_vld_o <= 1, go to HOLD.
  - Timer reaching TIMEOUT-1 with no mac_vld_i: err_o <= 1, go to GAP, no result.
  - mac_vld_i in any state other than WAIT is ignored.
- HOLD:
  - res_vld_o and res_o stay stable until res_rdy_i = 1.
  - On that cycle the handshake completes; res_vld_o drops next cycle; go to GAP.
- GAP:
  - Count GAP cycles, then go to IDLE.
  - mac_vld_o is guaranteed low for at least GAP cycles between bursts, including the time spent in WAIT and HOLD.
- Minimum start-to-start spacing: K + 1 + (MAC latency) + GAP cycles.
- No arithmetic on data; widths pass straight through.

Decomposition:
- Shared package fx_pkg:
  - WIDTH/FRACTION defaults.
  - FSM state encoding (3-bit typedef).
  - AW function (clog2 with minimum of 1).
  - GAP minimum constant (6), shared with fx_mac.
- One natural sub-module: fx_vec_buf, a K x WIDTH register file with one write port and one combinational read port, instantiated twice.

Test Plan:
- Loop with a real fx_mac (K=4, FRACTION=4):
  - Stimulus: weights 0x10 x4, data 0x10, 0x20, 0x08, 0x18; start.
  - Required: mac_vld_o high for exactly 4 cycles; res_o = 0x50; res_vld_o held until res_rdy_i.
- Saturation:
  - Stimulus: weights and data all 0x7F through fx_mac.
  - Required: res_o = 0x7F; err_o = 0.
- Timeout:
  - Stimulus: a bench MAC model never asserts mac_vld_i.
  - Required: err_o = 1 exactly 64 cycles after the burst ends; res_vld_o never rises; IDLE reached 6 cycles later; next start clears err_o.
- Backpressure and gating:
  - Stimulus: res_rdy_i low for 10 cycles; also pulse start_i and wr_en_i (addr 0, 0x55) during HOLD.
  - Required: res_o stable throughout; start ignored; wbuf[0] unchanged on the next burst.
- Back-to-back starts:
  - Stimulus: start_i pulsed every cycle.
  - Required: mac_vld_o low for at least 6 cycles between bursts; every burst returns the correct result.
- Reset mid-STREAM:
  - Stimulus: rstn low at element 2.
  - Required: next cycle mac_vld_o = 0 and busy_o = 0; buffers read 0; a late mac_vld_i is ignored.
